// File: rtl/qoi_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module : qoi_decoder_pkg
// Brief  : Shared QOI types, opcode constants, tag decode and pixel hash.
// Rev    : 1.0  initial release
// ============================================================================
package qoi_decoder_pkg;

  // Channel order matches the pixel sink: r in the low byte, a in the high byte.
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } pixel_t;

  typedef enum logic [2:0] {
    TAG_RGB,
    TAG_RGBA,
    TAG_INDEX,
    TAG_DIFF,
    TAG_LUMA,
    TAG_RUN
  } qoi_tag_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OP,
    ST_ARG,
    ST_EMIT,
    ST_DONE
  } qoi_state_t;

  localparam logic [7:0] QOI_OP_RGB  = 8'hFE;
  localparam logic [7:0] QOI_OP_RGBA = 8'hFF;

  // Full-byte opcodes win over the 2-bit tags they alias (11xxxxxx).
  function automatic qoi_tag_t qoi_decode_tag(input logic [7:0] op);
    qoi_tag_t t;
    if (op == QOI_OP_RGB)       t = TAG_RGB;
    else if (op == QOI_OP_RGBA) t = TAG_RGBA;
    else begin
      case (op[7:6])
        2'b00:   t = TAG_INDEX;
        2'b01:   t = TAG_DIFF;
        2'b10:   t = TAG_LUMA;
        default: t = TAG_RUN;
      endcase
    end
    return t;
  endfunction

  // Same hash as the encoder; 13 bits hold 255*26 without truncation.
  function automatic logic [5:0] qoi_hash(input pixel_t p);
    logic [12:0] sum;
    sum = 13'(p.r) * 13'd3 + 13'(p.g) * 13'd5 + 13'(p.b) * 13'd7 + 13'(p.a) * 13'd11;
    return 6'(sum);
  endfunction

endpackage
`default_nettype wire

// File: rtl/qoi_decoder_if.sv
`default_nettype none
// ============================================================================
// Module : qoi_decoder_if
// Brief  : Control, encoded-byte stream and pixel stream of the QOI decoder.
// Rev    : 1.0  initial release
// ============================================================================
interface qoi_decoder_if;
  logic        start;
  logic [29:0] size_i;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] px_o;
  logic        px_valid;
  logic        px_ready;
  logic        busy;
  logic        done;
  logic [29:0] count_o;

  modport master (
    output start, size_i, in_data, in_valid, px_ready,
    input  in_ready, px_o, px_valid, busy, done, count_o
  );

  modport slave (
    input  start, size_i, in_data, in_valid, px_ready,
    output in_ready, px_o, px_valid, busy, done, count_o
  );
endinterface
`default_nettype wire

// File: rtl/qoi_index_table.sv
`default_nettype none
// ============================================================================
// Module : qoi_index_table
// Brief  : 64-entry pixel table; combinational read, synchronous write,
//          synchronous clear of all entries.
// Rev    : 1.0  initial release
// ============================================================================
module qoi_index_table
  import qoi_decoder_pkg::*;
(
  input  wire logic   clk,
  input  wire logic   clear,
  input  wire logic   we,
  input  wire logic [5:0] wr_addr,
  input  wire pixel_t wr_data,
  input  wire logic [5:0] rd_addr,
  output pixel_t      rd_data
);

  localparam int ENTRIES = 64;

  pixel_t mem [ENTRIES];

  for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
    // Each entry clears on demand or captures the pixel hashed to it.
    always_ff @(posedge clk) begin
      if (clear)
        mem[i] <= '0;
      else if (we && (wr_addr == 6'(i)))
        mem[i] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/qoi_decoder.sv
`default_nettype none
// ============================================================================
// Module : qoi_decoder
// Brief  : Streaming QOI decoder, encoded bytes in, one 32-bit pixel per
//          handshake out, stops after size_i pixels.
// Rev    : 1.0  initial release
// ============================================================================
module qoi_decoder
  import qoi_decoder_pkg::*;
#(
  parameter logic [7:0] INIT_ALPHA = 8'h00
)(
  input  wire logic  clk,
  input  wire logic  rst,
  qoi_decoder_if.slave bus
);

  localparam pixel_t PREV_INIT = '{a: INIT_ALPHA, b: 8'h00, g: 8'h00, r: 8'h00};

  qoi_state_t  state;
  qoi_tag_t    tag;
  pixel_t      prev;
  pixel_t      px_q;
  logic        px_valid_q;
  logic [29:0] count;
  logic [29:0] size;
  logic [6:0]  run_left;
  logic [1:0]  arg_cnt;
  pixel_t      arg_px;
  logic [5:0]  luma_dg;

  logic        start_ok;
  logic        px_hs;
  logic [29:0] count_next;
  qoi_tag_t    op_tag;
  pixel_t      idx_px;
  pixel_t      diff_px;
  pixel_t      luma_px;
  pixel_t      arg_next;
  logic [7:0]  vg;
  logic        arg_last;

  assign start_ok   = bus.start && (state == ST_IDLE || state == ST_DONE);
  assign px_hs      = px_valid_q && bus.px_ready;
  assign count_next = count + 30'd1;
  assign op_tag     = qoi_decode_tag(bus.in_data);

  // DIFF: each channel offset by a 2-bit field biased by 2, mod 256.
  always_comb begin
    diff_px   = prev;
    diff_px.r = prev.r + {6'b0, bus.in_data[5:4]} - 8'd2;
    diff_px.g = prev.g + {6'b0, bus.in_data[3:2]} - 8'd2;
    diff_px.b = prev.b + {6'b0, bus.in_data[1:0]} - 8'd2;
  end

  // LUMA: green delta from the tag byte, red/blue deltas relative to it.
  assign vg = {2'b00, luma_dg} - 8'd32;
  always_comb begin
    luma_px   = prev;
    luma_px.r = prev.r + vg + {4'h0, bus.in_data[7:4]} - 8'd8;
    luma_px.g = prev.g + vg;
    luma_px.b = prev.b + vg + {4'h0, bus.in_data[3:0]} - 8'd8;
  end

  // RGB/RGBA: drop the incoming byte into the channel selected by arg_cnt.
  always_comb begin
    arg_next = arg_px;
    case (arg_cnt)
      2'd0:    arg_next.r = bus.in_data;
      2'd1:    arg_next.g = bus.in_data;
      2'd2:    arg_next.b = bus.in_data;
      default: arg_next.a = bus.in_data;
    endcase
  end

  assign arg_last = (tag == TAG_LUMA) ||
                    (tag == TAG_RGB  && arg_cnt == 2'd2) ||
                    (tag == TAG_RGBA && arg_cnt == 2'd3);

  qoi_index_table u_index (
    .clk     (clk),
    .clear   (rst || start_ok),
    .we      (px_hs),
    .wr_addr (qoi_hash(px_q)),
    .wr_data (px_q),
    .rd_addr (bus.in_data[5:0]),
    .rd_data (idx_px)
  );

  // Decoder FSM: op fetch, argument collection, pixel emission and run repeat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      tag        <= TAG_RGB;
      prev       <= PREV_INIT;
      px_q       <= '0;
      px_valid_q <= 1'b0;
      count      <= '0;
      size       <= '0;
      run_left   <= '0;
      arg_cnt    <= '0;
      arg_px     <= '0;
      luma_dg    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            size  <= bus.size_i;
            count <= '0;
            prev  <= PREV_INIT;
            state <= (bus.size_i == 30'd0) ? ST_DONE : ST_OP;
          end
        end
        ST_OP: begin
          if (bus.in_valid) begin
            tag      <= op_tag;
            arg_cnt  <= '0;
            arg_px   <= prev;
            luma_dg  <= bus.in_data[5:0];
            run_left <= 7'd1;
            case (op_tag)
              TAG_INDEX: begin
                px_q <= idx_px; px_valid_q <= 1'b1; state <= ST_EMIT;
              end
              TAG_DIFF: begin
                px_q <= diff_px; px_valid_q <= 1'b1; state <= ST_EMIT;
              end
              TAG_RUN: begin
                px_q       <= prev;
                px_valid_q <= 1'b1;
                run_left   <= {1'b0, bus.in_data[5:0]} + 7'd1;
                state      <= ST_EMIT;
              end
              default: state <= ST_ARG;
            endcase
          end
        end
        ST_ARG: begin
          if (bus.in_valid) begin
            arg_cnt <= arg_cnt + 2'd1;
            arg_px  <= arg_next;
            if (arg_last) begin
              px_q       <= (tag == TAG_LUMA) ? luma_px : arg_next;
              px_valid_q <= 1'b1;
              state      <= ST_EMIT;
            end
          end
        end
        ST_EMIT: begin
          if (bus.px_ready) begin
            count <= count_next;
            prev  <= px_q;
            if (count_next == size) begin
              px_valid_q <= 1'b0;
              state      <= ST_DONE;
            end else if (run_left > 7'd1) begin
              run_left <= run_left - 7'd1;
            end else begin
              px_valid_q <= 1'b0;
              state      <= ST_OP;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready = (state == ST_OP) || (state == ST_ARG);
  assign bus.busy     = (state == ST_OP) || (state == ST_ARG) || (state == ST_EMIT);
  assign bus.done     = (state == ST_DONE);
  assign bus.px_o     = px_q;
  assign bus.px_valid = px_valid_q;
  assign bus.count_o  = count;

endmodule
`default_nettype wire

// File: tb/tb_qoi_decoder.sv
`default_nettype none
// ============================================================================
// Module : tb_qoi_decoder
// Brief  : Scoreboard bench for qoi_decoder with directed byte streams.
// Rev    : 1.0  initial release
// ============================================================================
module tb_qoi_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  qoi_decoder_if bus ();

  qoi_decoder #(.INIT_ALPHA(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int sink_mode = 0;      // 0: always ready, 1: toggle, 2: held low
  logic [31:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Sink: choose px_ready for the coming edge, then check any handshake it makes.
  always @(negedge clk) begin
    case (sink_mode)
      0:       bus.px_ready = 1'b1;
      1:       bus.px_ready = ~bus.px_ready;
      default: bus.px_ready = 1'b0;
    endcase
    if (!rst && bus.px_valid && bus.px_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL px_unexpected: got %h expected none", bus.px_o);
      end else begin
        chk("px_o", bus.px_o, exp_q.pop_front());
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic do_start(input logic [29:0] sz);
    bus.start  = 1'b1;
    bus.size_i = sz;
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  task automatic wait_done(input logic [29:0] exp_count);
    int n = 0;
    while (!bus.done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("done", 32'(bus.done), 32'd1);
    chk("count_o", 32'(bus.count_o), 32'(exp_count));
    chk("in_ready_done", 32'(bus.in_ready), 32'd0);
    chk("busy_done", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int accepted;
    int n;
    bus.start    = 1'b0;
    bus.size_i   = '0;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.px_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_px_valid", 32'(bus.px_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_count", 32'(bus.count_o), 32'd0);
    chk("rst_px_o", bus.px_o, 32'd0);

    // size 0 finishes immediately
    do_start(30'd0);
    chk("size0_done", 32'(bus.done), 32'd1);

    // RGB single pixel
    exp_q.push_back(32'h00302010);
    do_start(30'd1);
    chk("busy_op", 32'(bus.busy), 32'd1);
    send_byte(8'hFE); send_byte(8'h10); send_byte(8'h20); send_byte(8'h30);
    wait_done(30'd1);

    // RGB then INDEX of its hash (16*3+32*5+48*7 = 544 -> 32)
    exp_q.push_back(32'h00302010);
    exp_q.push_back(32'h00302010);
    do_start(30'd2);
    send_byte(8'hFE); send_byte(8'h10); send_byte(8'h20); send_byte(8'h30);
    send_byte(8'h20);
    wait_done(30'd2);

    // RGBA, DIFF all -2 (wraps r), INDEX of first pixel (hash 78 -> 14)
    exp_q.push_back(32'h04030201);
    exp_q.push_back(32'h040100FF);
    exp_q.push_back(32'h04030201);
    do_start(30'd3);
    send_byte(8'hFF); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h40);
    send_byte(8'h0E);
    wait_done(30'd3);

    // LUMA: zero deltas, then vg=-1 with dr/db bias -8 -> r=b=0-1-8=F7, g=FF
    exp_q.push_back(32'h00000000);
    exp_q.push_back(32'h00F7FFF7);
    do_start(30'd2);
    send_byte(8'hA0); send_byte(8'h88);
    send_byte(8'h9F); send_byte(8'h00);
    wait_done(30'd2);

    // RUN of 62 with toggling px_ready
    sink_mode = 1;
    exp_q.push_back(32'h00332211);
    for (int i = 0; i < 62; i++) exp_q.push_back(32'h00332211);
    do_start(30'd63);
    send_byte(8'hFE); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'hFD);
    wait_done(30'd63);
    sink_mode = 0;

    // Truncation: run of 10 cut at size 5, trailing byte untouched
    exp_q.push_back(32'h00CCBBAA);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h00CCBBAA);
    do_start(30'd5);
    send_byte(8'hFE); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    send_byte(8'hC9);
    wait_done(30'd5);
    accepted = 0;
    bus.in_data  = 8'h55;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.in_ready) accepted++;
    end
    bus.in_valid = 1'b0;
    chk("trailing_not_consumed", 32'(accepted), 32'd0);
    chk("done_held", 32'(bus.done), 32'd1);

    // Reset in the middle of a stalled run
    exp_q.push_back(32'h00010101);
    do_start(30'd10);
    send_byte(8'hFE); send_byte(8'h01); send_byte(8'h01); send_byte(8'h01);
    n = 0;
    while (bus.count_o != 30'd1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("first_px_count", 32'(bus.count_o), 32'd1);
    sink_mode = 2;
    send_byte(8'hC5);
    repeat (3) @(negedge clk);
    chk("stall_px_valid", 32'(bus.px_valid), 32'd1);
    chk("stall_px_o", bus.px_o, 32'h00010101);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_px_valid", 32'(bus.px_valid), 32'd0);
    chk("midrst_count", 32'(bus.count_o), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    sink_mode = 0;
    @(negedge clk);
    exp_q.push_back(32'h00000000);
    do_start(30'd1);
    send_byte(8'h0F);
    wait_done(30'd1);

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
